serial_rx_deframer: RTL and testbench
=====================================

Name: serial_rx_deframer

Overview:
- Front-end stage directly upstream of the RX latch.
- Turns the 1-bit serial line into 8-bit bytes, using an asynchronous start/stop framing with a configurable oversampling ratio.
- Each good byte is presented on data_out with a one-cycle data_valid. data_valid drives en_Rx and data_out drives in_data of the RX stage.
- Framing and parity errors are flagged. Bytes with errors are never delivered.

Parameters:
- OVS, 4: clk_rx cycles per serial bit. Must be even and ≥ 4.
- PARITY_EN, 0: 1 = one parity bit follows the data bits, before the stop bit.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity. Ignored when PARITY_EN = 0.

Ports:
- clk_rx, input, 1: single clock. All logic is on the rising edge.
- rst, input, 1: asynchronous, active-low reset. rst = 0 resets immediately. Release is on a clock edge.
- serial_in, input, 1: asynchronous serial line. Idle level is 1.
- data_out, output, 8: last good byte, LSB received first. Held until the next good byte.
- data_valid, output, 1: one-cycle pulse when data_out updates. Connects to en_Rx of the RX stage.
- frame_err, output, 1: one-cycle pulse when the stop bit is sampled as 0.
- parity_err, output, 1: one-cycle pulse on parity mismatch.
- busy, output, 1: high whenever the FSM is not in IDLE.

Behaviour:
- Reset values while rst = 0: data_out = 8'h00, data_valid = 0, frame_err = 0, parity_err = 0, busy = 0. State = IDLE, counters = 0, shift register = 0, synchronizer flops = 1.
- Input synchronizer:
  - serial_in passes through 2 flops to give serial_s. The FSM sees only serial_s.
  - Latency is 2 edges.
- Timing reference: D is the edge at which IDLE samples serial_s = 0.
  - Start sample at D + OVS/2.
  - Data bit k (k = 0..7) sampled at D + OVS/2 + (k+1)*OVS.
  - Parity sampled at D + OVS/2 + 9*OVS.
  - Stop sampled at D + OVS/2 + (9+PARITY_EN)*OVS.
- Outputs: data_valid, frame_err and parity_err are registered. Each is set by the stop-sample edge and cleared on the next edge.
- Worked example, OVS = 4, no parity: data_valid goes high 38 edges after D and stays high for exactly 1 cycle.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - IDLE: on serial_s = 0, go to START and clear the bit-timer.
  - START: at the mid-bit sample:
    - serial_s = 0: go to DATA, bit index = 0.
    - serial_s = 1: false start, return to IDLE. No flags.
  - DATA: every OVS cycles, shift the sample in. The sample goes to bit 7 and the register shifts right. Computed parity accumulates. After bit 7, go to PARITY if PARITY_EN = 1, otherwise STOP.
  - PARITY: sample one bit. Compare it with the XOR of the data bits, inverted if PARITY_ODD = 1. Record a mismatch. Go to STOP.
  - STOP, on its sample:
    - serial_s = 1 and no parity mismatch: data_out ← shift register, data_valid pulse, go to IDLE.
    - serial_s = 1 and parity mismatch: parity_err pulse, data_out unchanged, go to IDLE.
    - serial_s = 0: frame_err pulse, no data_valid, data_out unchanged, go to WAIT_HIGH. This applies even when parity also mismatched; frame_err takes priority and parity_err is not pulsed.
  - WAIT_HIGH: stay until serial_s = 1, then go to IDLE. This stops a break condition from retriggering the FSM.
- Back-to-back frames: a new start may be detected on the edge immediately after the return to IDLE. No idle gap is required beyond the stop bit.
- Error pulses are mutually exclusive per frame, and both are exclusive with data_valid.
- Reset mid-frame: all state is discarded immediately. After release, the first frame starting on a high line is received correctly.
- Bit-timer width: clog2(OVS). Bit index: 3 bits. Wrap-around happens only under FSM control.

Test Plan:
- Reset with serial_in = 1: all outputs are 0 and busy = 0. Release and idle 20 cycles: no pulses.
- Frame 0xA5, OVS = 4, no parity (start 0, bits 1,0,1,0,0,1,0,1, stop 1): data_out = 0xA5, data_valid high for 1 cycle at exactly D + 38, no error pulses.
- Glitch, serial_in = 0 for 1 bit-time/2 − 1 cycles: FSM returns to IDLE, no data_valid, no frame_err, data_out unchanged (0xA5).
- Frame 0x3C with stop bit = 0, line held 0 for 3 further bit-times: single frame_err pulse, data_out stays 0xA5, busy stays high until the line returns to 1. A following 0x5A frame is then received.
- PARITY_EN = 1 (even), byte 0x81 sent with parity bit 1: parity_err pulse, no data_valid. Same byte with parity bit 0: data_valid with data_out = 0x81.
- rst low during data bit 4 of a 0xFF frame: outputs clear immediately. After release, back-to-back frames 0x12 then 0x34 give two data_valid pulses with the correct bytes, exactly 10*OVS cycles apart.

Source files
------------

// File: rtl/serial_rx_deframer_if.sv
// Byte-side and line-side signals of the serial RX deframer.
// The deframer uses the slave view; whoever drives the line and consumes
// the bytes uses the master view.
interface serial_rx_deframer_if;
    logic       serial_in;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    modport master (
        output serial_in,
        input  data_out,
        input  data_valid,
        input  frame_err,
        input  parity_err,
        input  busy
    );

    modport slave (
        input  serial_in,
        output data_out,
        output data_valid,
        output frame_err,
        output parity_err,
        output busy
    );
endinterface

// File: rtl/serial_rx_deframer.sv
// Serial RX deframer: turns an oversampled asynchronous start/stop serial
// line into bytes. A frame is start(0), 8 data bits LSB first, an optional
// parity bit and a stop(1). Good bytes are presented with a one-cycle
// data_valid; framing and parity errors give one-cycle flags and the byte
// is dropped. All outputs are registered.
module serial_rx_deframer #(
    parameter int OVS        = 4,
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                  clk_rx,
    input  logic                  rst,
    serial_rx_deframer_if.slave   bus
);

    localparam int TW = $clog2(OVS);
    localparam logic [TW-1:0] T_ZERO = TW'(0);
    localparam logic [TW-1:0] T_ONE  = TW'(1);
    localparam logic [TW-1:0] T_HALF = TW'(OVS / 2 - 1);
    localparam logic [TW-1:0] T_FULL = TW'(OVS - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } state_t;

    // True when the received parity bit disagrees with the accumulated data parity.
    function automatic logic parity_mismatch(input logic sample, input logic acc);
        return sample != (acc ^ PARITY_ODD);
    endfunction

    logic          sync1_r;
    logic          sync2_r;
    logic          serial_s;
    state_t        state_r,      state_nx;
    logic [TW-1:0] timer_r,      timer_nx;
    logic [2:0]    idx_r,        idx_nx;
    logic [7:0]    shift_r,      shift_nx;
    logic          par_acc_r,    par_acc_nx;
    logic          par_bad_r,    par_bad_nx;
    logic [7:0]    data_out_r,   data_out_nx;
    logic          data_valid_r, data_valid_nx;
    logic          frame_err_r,  frame_err_nx;
    logic          parity_err_r, parity_err_nx;
    logic          busy_r;
    logic          tick_half_s;
    logic          tick_full_s;

    assign serial_s    = sync2_r;
    assign tick_half_s = (timer_r == T_HALF);
    assign tick_full_s = (timer_r == T_FULL);

    // Two-flop synchronizer; flops reset to the idle line level.
    always_ff @(posedge clk_rx or negedge rst) begin
        if (!rst) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= bus.serial_in;
            sync2_r <= sync1_r;
        end
    end

    // Next-state, bit timing, shifting, parity tracking and output pulses.
    always_comb begin
        state_nx      = state_r;
        timer_nx      = timer_r;
        idx_nx        = idx_r;
        shift_nx      = shift_r;
        par_acc_nx    = par_acc_r;
        par_bad_nx    = par_bad_r;
        data_out_nx   = data_out_r;
        data_valid_nx = 1'b0;
        frame_err_nx  = 1'b0;
        parity_err_nx = 1'b0;

        case (state_r)
            IDLE: begin
                timer_nx = T_ZERO;
                if (!serial_s) begin
                    state_nx   = START;
                    par_acc_nx = 1'b0;
                    par_bad_nx = 1'b0;
                end else begin
                    state_nx = IDLE;
                end
            end

            START: begin
                if (tick_half_s) begin
                    timer_nx = T_ZERO;
                    idx_nx   = 3'd0;
                    // A line back at 1 by mid start bit is a glitch, not a frame.
                    if (!serial_s) begin
                        state_nx = DATA;
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    timer_nx = timer_r + T_ONE;
                end
            end

            DATA: begin
                if (tick_full_s) begin
                    timer_nx   = T_ZERO;
                    shift_nx   = {serial_s, shift_r[7:1]};
                    par_acc_nx = par_acc_r ^ serial_s;
                    if (idx_r == 3'd7) begin
                        idx_nx   = 3'd0;
                        state_nx = PARITY_EN ? PARITY : STOP;
                    end else begin
                        idx_nx = idx_r + 3'd1;
                    end
                end else begin
                    timer_nx = timer_r + T_ONE;
                end
            end

            PARITY: begin
                if (tick_full_s) begin
                    timer_nx   = T_ZERO;
                    par_bad_nx = parity_mismatch(serial_s, par_acc_r);
                    state_nx   = STOP;
                end else begin
                    timer_nx = timer_r + T_ONE;
                end
            end

            STOP: begin
                if (tick_full_s) begin
                    timer_nx = T_ZERO;
                    if (!serial_s) begin
                        // Framing error outranks a parity error on the same frame.
                        frame_err_nx = 1'b1;
                        state_nx     = WAIT_HIGH;
                    end else if (par_bad_r) begin
                        parity_err_nx = 1'b1;
                        state_nx      = IDLE;
                    end else begin
                        data_out_nx   = shift_r;
                        data_valid_nx = 1'b1;
                        state_nx      = IDLE;
                    end
                end else begin
                    timer_nx = timer_r + T_ONE;
                end
            end

            WAIT_HIGH: begin
                // Hold off until a break ends so it cannot look like a new start.
                timer_nx = T_ZERO;
                if (serial_s) begin
                    state_nx = IDLE;
                end else begin
                    state_nx = WAIT_HIGH;
                end
            end

            default: begin
                state_nx = IDLE;
                timer_nx = T_ZERO;
                idx_nx   = 3'd0;
            end
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk_rx or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            timer_r      <= T_ZERO;
            idx_r        <= 3'd0;
            shift_r      <= 8'h00;
            par_acc_r    <= 1'b0;
            par_bad_r    <= 1'b0;
            data_out_r   <= 8'h00;
            data_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
            parity_err_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_nx;
            timer_r      <= timer_nx;
            idx_r        <= idx_nx;
            shift_r      <= shift_nx;
            par_acc_r    <= par_acc_nx;
            par_bad_r    <= par_bad_nx;
            data_out_r   <= data_out_nx;
            data_valid_r <= data_valid_nx;
            frame_err_r  <= frame_err_nx;
            parity_err_r <= parity_err_nx;
            busy_r       <= (state_nx != IDLE);
        end
    end

    assign bus.data_out   = data_out_r;
    assign bus.data_valid = data_valid_r;
    assign bus.frame_err  = frame_err_r;
    assign bus.parity_err = parity_err_r;
    assign bus.busy       = busy_r;

endmodule

// File: tb/tb_serial_rx_deframer.sv
// Bench for serial_rx_deframer. Three instances: OVS=4 no parity, OVS=4
// even parity, OVS=6 odd parity. The sender pushes the expected event
// (kind, byte, cycle it must appear) into a per-instance queue; per-instance
// monitors pop and compare whenever a flag/valid pulse is seen.
module tb_serial_rx_deframer;

    typedef struct {
        logic [2:0] kind;   // {data_valid, frame_err, parity_err}
        logic [7:0] data;
        int         cyc;
    } exp_t;

    localparam int OVS_OF  [3] = '{4, 4, 6};
    localparam int PEN_OF  [3] = '{0, 1, 1};
    localparam bit PODD_OF [3] = '{1'b0, 1'b0, 1'b1};

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t expq [3][$];
    logic [7:0] held [3];

    serial_rx_deframer_if if0 ();
    serial_rx_deframer_if if1 ();
    serial_rx_deframer_if if2 ();

    serial_rx_deframer #(.OVS(4), .PARITY_EN(1'b0), .PARITY_ODD(1'b0))
        dut0 (.clk_rx(clk), .rst(rst), .bus(if0));
    serial_rx_deframer #(.OVS(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b0))
        dut1 (.clk_rx(clk), .rst(rst), .bus(if1));
    serial_rx_deframer #(.OVS(6), .PARITY_EN(1'b1), .PARITY_ODD(1'b1))
        dut2 (.clk_rx(clk), .rst(rst), .bus(if2));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_line(input int inst, input logic v);
        case (inst)
            0:       if0.serial_in = v;
            1:       if1.serial_in = v;
            default: if2.serial_in = v;
        endcase
    endtask

    task automatic get_out(input int inst, output logic [7:0] d, output logic [3:0] f);
        case (inst)
            0: begin d = if0.data_out; f = {if0.data_valid, if0.frame_err, if0.parity_err, if0.busy}; end
            1: begin d = if1.data_out; f = {if1.data_valid, if1.frame_err, if1.parity_err, if1.busy}; end
            default: begin d = if2.data_out; f = {if2.data_valid, if2.frame_err, if2.parity_err, if2.busy}; end
        endcase
    endtask

    task automatic check_busy(input int inst, input logic exp);
        logic [7:0] d;
        logic [3:0] f;
        get_out(inst, d, f);
        check($sformatf("busy%0d", inst), {31'd0, f[0]}, {31'd0, exp});
    endtask

    task automatic check_reset_outputs(input int inst);
        logic [7:0] d;
        logic [3:0] f;
        get_out(inst, d, f);
        check($sformatf("rst_data%0d", inst), {24'd0, d}, 32'd0);
        check($sformatf("rst_flags%0d", inst), {28'd0, f}, 32'd0);
    endtask

    // Scoreboard side: pop expectation on every pulse and compare.
    task automatic mon(input int inst, input logic dv, input logic fe, input logic pe,
                       input logic [7:0] dout);
        exp_t e;
        logic [2:0] k;
        k = {dv, fe, pe};
        if (rst !== 1'b1 || k == 3'b000) return;
        if (expq[inst].size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_pulse%0d: got flags %b at cycle %0d, expected no pulse",
                     inst, k, cyc);
            return;
        end
        e = expq[inst].pop_front();
        check($sformatf("kind%0d", inst), {29'd0, k}, {29'd0, e.kind});
        check($sformatf("cycle%0d", inst), cyc, e.cyc);
        check($sformatf("data%0d", inst), {24'd0, dout},
              {24'd0, (e.kind == 3'b100) ? e.data : held[inst]});
        if (e.kind == 3'b100) held[inst] = e.data;
    endtask

    always @(negedge clk) mon(0, if0.data_valid, if0.frame_err, if0.parity_err, if0.data_out);
    always @(negedge clk) mon(1, if1.data_valid, if1.frame_err, if1.parity_err, if1.data_out);
    always @(negedge clk) mon(2, if2.data_valid, if2.frame_err, if2.parity_err, if2.data_out);

    // Reference model: a frame whose start is driven after edge n is detected
    // at edge D = n + 3 (two synchronizer flops), stop sampled at
    // D + OVS/2 + (9 + PEN)*OVS; the registered flag is seen after that edge.
    task automatic send(input int inst, input logic [7:0] b, input logic par_flip,
                        input logic stop_bit, input int low_bits);
        exp_t e;
        int ovs;
        int pen;
        logic pbit;
        ovs  = OVS_OF[inst];
        pen  = PEN_OF[inst];
        pbit = (^b) ^ PODD_OF[inst] ^ par_flip;
        e.data = b;
        e.cyc  = cyc + 3 + ovs / 2 + (9 + pen) * ovs;
        if (!stop_bit)                     e.kind = 3'b010;
        else if (pen == 1 && par_flip)     e.kind = 3'b001;
        else                               e.kind = 3'b100;
        expq[inst].push_back(e);
        set_line(inst, 1'b0);
        repeat (ovs) tick();
        for (int i = 0; i < 8; i++) begin
            set_line(inst, b[i]);
            repeat (ovs) tick();
        end
        if (pen == 1) begin
            set_line(inst, pbit);
            repeat (ovs) tick();
        end
        set_line(inst, stop_bit);
        repeat (ovs) tick();
        if (!stop_bit) repeat (low_bits * ovs) tick();
    endtask

    task automatic release_line(input int inst);
        set_line(inst, 1'b1);
        repeat (OVS_OF[inst]) tick();
    endtask

    initial begin
        logic [7:0] rb;
        logic       rflip;
        logic       rstop;
        int         inst;
        for (int i = 0; i < 3; i++) held[i] = 8'h00;
        if0.serial_in = 1'b1;
        if1.serial_in = 1'b1;
        if2.serial_in = 1'b1;

        // Reset state, then quiet idle line after release.
        repeat (3) tick();
        for (int i = 0; i < 3; i++) check_reset_outputs(i);
        rst = 1'b1;
        repeat (20) begin
            tick();
            for (int i = 0; i < 3; i++) check_busy(i, 1'b0);
        end

        // 0xA5, no parity, timing checked via scoreboard cycle.
        send(0, 8'hA5, 1'b0, 1'b1, 0);
        repeat (8) tick();

        // Short glitch: rejected at the mid start-bit sample.
        set_line(0, 1'b0);
        tick();
        set_line(0, 1'b1);
        repeat (10) tick();
        check_busy(0, 1'b0);
        check("glitch_data", {24'd0, if0.data_out}, 32'h0000_00A5);

        // Framing error with a break; busy stays up until the line recovers.
        send(0, 8'h3C, 1'b0, 1'b0, 3);
        check_busy(0, 1'b1);
        check("break_data", {24'd0, if0.data_out}, 32'h0000_00A5);
        release_line(0);
        check_busy(0, 1'b0);
        send(0, 8'h5A, 1'b0, 1'b1, 0);

        // Even parity: 0x81 with parity 1 is bad, with parity 0 is good.
        send(1, 8'h81, 1'b1, 1'b1, 0);
        send(1, 8'h81, 1'b0, 1'b1, 0);
        repeat (8) tick();

        // Randomized frames across all three configurations.
        for (int i = 0; i < 36; i++) begin
            inst  = i % 3;
            rb    = 8'($urandom);
            rflip = ($urandom_range(0, 3) == 0);
            rstop = ($urandom_range(0, 5) != 0);
            send(inst, rb, rflip, rstop, int'($urandom_range(0, 2)));
            if (!rstop) release_line(inst);
            repeat ($urandom_range(0, 5)) tick();
        end
        repeat (20) tick();

        // Reset in the middle of data bit 4 of a 0xFF frame on instance 0.
        set_line(0, 1'b0);
        repeat (4) tick();
        set_line(0, 1'b1);
        repeat (4 * 4 + 2) tick();
        rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check_reset_outputs(i);
            held[i] = 8'h00;
        end
        repeat (3) tick();
        rst = 1'b1;
        repeat (2) tick();

        // Back-to-back frames; cycle expectations put them 10*OVS apart.
        send(0, 8'h12, 1'b0, 1'b1, 0);
        send(0, 8'h34, 1'b0, 1'b1, 0);

        repeat (60) tick();
        for (int i = 0; i < 3; i++)
            check($sformatf("pending%0d", i), expq[i].size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
